// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ALU sequential divide path. The dividend,
// quotient, remainder and divisor registers all use word_t so their widths
// stay in step.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;
    // Needs one more bit than log2(DATA_W) so it can hold the value DATA_W.
    localparam int LZC_W  = $clog2(DATA_W) + 1;

    typedef logic [DATA_W-1:0] word_t;

endpackage : alu_pkg

// File: rtl/divisor_reg_if.sv
// ----------------------------------------------------------------------------
// divisor_reg_if
// Bundles the write side and the read side of the divisor holding register.
//   divisor_in   : value to capture (master -> slave)
//   wrctrl       : capture strobe   (master -> slave)
//   divisor_out  : stored divisor   (slave -> master)
//   divisor_zero : stored divisor is zero (slave -> master)
//   divisor_lzc  : leading-zero count of the stored divisor (slave -> master)
// The master modport belongs to the divide control; the slave modport belongs
// to divisor_reg.
// ----------------------------------------------------------------------------
interface divisor_reg_if #(
    parameter int WIDTH = 32,
    parameter int LZC_W = $clog2(WIDTH) + 1
);

    logic [WIDTH-1:0] divisor_in;
    logic             wrctrl;
    logic [WIDTH-1:0] divisor_out;
    logic             divisor_zero;
    logic [LZC_W-1:0] divisor_lzc;

    modport master (
        output divisor_in,
        output wrctrl,
        input  divisor_out,
        input  divisor_zero,
        input  divisor_lzc
    );

    modport slave (
        input  divisor_in,
        input  wrctrl,
        output divisor_out,
        output divisor_zero,
        output divisor_lzc
    );

endinterface : divisor_reg_if

// File: rtl/lzc_count.sv
// ----------------------------------------------------------------------------
// lzc_count
// Parameterized leading-zero counter. It counts the consecutive zero bits
// starting at the MSB of value. An all-zero input gives WIDTH. The remainder
// normalizer also uses this block.
//   value : WIDTH-bit input word
//   count : LZC_W-bit leading-zero count (0 .. WIDTH)
// ----------------------------------------------------------------------------
module lzc_count #(
    parameter int WIDTH = 32,
    parameter int LZC_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] value,
    output logic [LZC_W-1:0] count
);

    // The scan runs from the LSB upward, so the highest set bit is the last
    // one written. That bit fixes the count.
    always_comb begin
        count = LZC_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = LZC_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule : lzc_count

// File: rtl/divisor_reg.sv
// ----------------------------------------------------------------------------
// divisor_reg
// Holding register for the divisor of the 32-bit sequential divider. It
// captures divisor_in on wrctrl and holds the value for the whole division.
// It also exports a zero flag and a leading-zero count. Both are derived only
// from the stored value, so divisor_in has no path to any output.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; it takes priority over wrctrl
//   bus  : divisor_reg_if.slave (divisor_in, wrctrl, divisor_out,
//          divisor_zero, divisor_lzc)
// Build option: define DIVISOR_LZC_EN to include the leading-zero counter.
// Without it, divisor_lzc reads 0 and the port list does not change.
// ----------------------------------------------------------------------------
module divisor_reg
    import alu_pkg::DATA_W;
#(
    parameter int WIDTH = DATA_W,
    parameter int LZC_W = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    divisor_reg_if.slave    bus
);

    logic [WIDTH-1:0] div_q;

    // Storage: reset clears the register, a write loads it, and otherwise it
    // holds. Back-to-back writes reload on every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (bus.wrctrl) begin
            div_q <= bus.divisor_in;
        end
    end

    assign bus.divisor_out  = div_q;
    assign bus.divisor_zero = (div_q == '0);

`ifdef DIVISOR_LZC_EN
    lzc_count #(
        .WIDTH (WIDTH),
        .LZC_W (LZC_W)
    ) u_lzc (
        .value (div_q),
        .count (bus.divisor_lzc)
    );
`else
    assign bus.divisor_lzc = '0;
`endif

endmodule : divisor_reg

// File: tb/tb_divisor_reg.sv
// ----------------------------------------------------------------------------
// tb_divisor_reg
// Directed, self-checking bench for divisor_reg. Inputs change on the falling
// edge, and outputs are sampled 1 ns after the rising edge. The expected
// leading-zero counts follow DIVISOR_LZC_EN.
// ----------------------------------------------------------------------------
module tb_divisor_reg;
    import alu_pkg::*;

`ifdef DIVISOR_LZC_EN
    localparam bit LZC_ON = 1'b1;
`else
    localparam bit LZC_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    divisor_reg_if #(.WIDTH(DATA_W), .LZC_W(LZC_W)) bus ();

    divisor_reg #(
        .WIDTH (DATA_W),
        .LZC_W (LZC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of inputs on the falling edge, then wait past the next
    // rising edge so the outputs have settled.
    task automatic applyStimulus(input logic r, input logic wr, input word_t din);
        @(negedge clk);
        rst            = r;
        bus.wrctrl     = wr;
        bus.divisor_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic word_t lzc_exp(input int n);
        return LZC_ON ? word_t'(n) : word_t'(0);
    endfunction

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.wrctrl     = 1'b0;
        bus.divisor_in = '0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("reset_out",  bus.divisor_out, 32'd0);
        checkOutput("reset_zero", word_t'(bus.divisor_zero), 32'd1);
        checkOutput("reset_lzc",  word_t'(bus.divisor_lzc), lzc_exp(32));

        // Load 50, then hold it.
        applyStimulus(1'b0, 1'b1, 32'd50);
        checkOutput("load_out",  bus.divisor_out, 32'd50);
        checkOutput("load_zero", word_t'(bus.divisor_zero), 32'd0);
        checkOutput("load_lzc",  word_t'(bus.divisor_lzc), lzc_exp(26));
        applyStimulus(1'b0, 1'b0, 32'd50);
        checkOutput("load_hold", bus.divisor_out, 32'd50);

        // Reset after a load, then reload.
        applyStimulus(1'b1, 1'b0, 32'd50);
        checkOutput("rst_after_load", bus.divisor_out, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd50);
        checkOutput("reload_out", bus.divisor_out, 32'd50);

        // Input changes while wrctrl is low must not reach the outputs.
        @(negedge clk);
        bus.wrctrl     = 1'b0;
        bus.divisor_in = 32'd9832;
        #1;
        checkOutput("no_comb_path", bus.divisor_out, 32'd50);
        applyStimulus(1'b0, 1'b0, 32'd9832);
        checkOutput("hold_edge1", bus.divisor_out, 32'd50);
        applyStimulus(1'b0, 1'b0, 32'd9832);
        checkOutput("hold_edge2", bus.divisor_out, 32'd50);
        applyStimulus(1'b0, 1'b1, 32'd9832);
        checkOutput("write_out", bus.divisor_out, 32'd9832);
        checkOutput("write_lzc", word_t'(bus.divisor_lzc), lzc_exp(18));

        // Back-to-back writes: the last value wins.
        applyStimulus(1'b0, 1'b1, 32'd7);
        applyStimulus(1'b0, 1'b1, 32'd1000);
        checkOutput("b2b_out", bus.divisor_out, 32'd1000);

        // Reset takes priority over a write on the same edge.
        applyStimulus(1'b1, 1'b1, 32'h1234_5678);
        checkOutput("prio_out",  bus.divisor_out, 32'd0);
        checkOutput("prio_zero", word_t'(bus.divisor_zero), 32'd1);
        checkOutput("prio_lzc",  word_t'(bus.divisor_lzc), lzc_exp(32));

        // Leading-zero count at its bounds.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        checkOutput("ones_out", bus.divisor_out, 32'hFFFF_FFFF);
        checkOutput("ones_lzc", word_t'(bus.divisor_lzc), lzc_exp(0));
        applyStimulus(1'b0, 1'b1, 32'h0000_0001);
        checkOutput("one_out",  bus.divisor_out, 32'h0000_0001);
        checkOutput("one_zero", word_t'(bus.divisor_zero), 32'd0);
        checkOutput("one_lzc",  word_t'(bus.divisor_lzc), lzc_exp(31));
        applyStimulus(1'b0, 1'b1, 32'h8000_0000);
        checkOutput("msb_out", bus.divisor_out, 32'h8000_0000);
        checkOutput("msb_lzc", word_t'(bus.divisor_lzc), lzc_exp(0));
        applyStimulus(1'b0, 1'b1, 32'h0001_0000);
        checkOutput("mid_lzc", word_t'(bus.divisor_lzc), lzc_exp(15));

        // Writing zero explicitly raises the zero flag again.
        applyStimulus(1'b0, 1'b1, 32'd0);
        checkOutput("wr0_zero", word_t'(bus.divisor_zero), 32'd1);
        checkOutput("wr0_lzc",  word_t'(bus.divisor_lzc), lzc_exp(32));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_divisor_reg
